// File: rtl/fdiv_unit.sv
// Binary32 divider y = x1/x2 (radix-2 restoring), done 28 cycles after start; start ignored while busy.
// Optional IEEE zero/inf/NaN handling when FDIV_SPECIAL_EN is defined.
module fdiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, DIV, RND} state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [25:0]       rem_q, rem_d, quo_q, quo_d;
    logic signed [9:0] exp_q, exp_d;
    logic [31:0]       y_q, y_d;
    logic              ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

    logic [23:0]       m1, m2;
    logic              lt, sgn, rnd_up;
    logic [24:0]       sum;
    logic signed [9:0] exp_r;
    logic [22:0]       frac_r;

    always_comb begin
        m1     = {1'b1, a_q[22:0]};
        m2     = {1'b1, b_q[22:0]};
        lt     = m1 < m2;
        sgn    = a_q[31] ^ b_q[31];
        // quo_q = 24 significand bits, guard, round; leftover remainder is the sticky bit
        rnd_up = quo_q[1] & (quo_q[0] | (|rem_q) | quo_q[2]);
        sum    = {1'b0, quo_q[25:2]} + {24'd0, rnd_up};
        exp_r  = sum[24] ? exp_q + 10'sd1 : exp_q;
        frac_r = sum[24] ? sum[23:1] : sum[22:0];
    end

`ifdef FDIV_SPECIAL_EN
    logic a_zero, b_zero, a_inf, b_inf, spec_nan;
    always_comb begin
        a_zero   = (a_q[30:23] == 8'h00);
        b_zero   = (b_q[30:23] == 8'h00);
        a_inf    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
        spec_nan = ((a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0)) ||
                   ((b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0)) ||
                   (a_zero && b_zero) || (a_inf && b_inf);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        y_d     = y_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // busy_q still high here means this is the done cycle, where start is ignored
                busy_d = 1'b0;
                if (start && !busy_q) begin
                    a_d     = x1;
                    b_d     = x2;
                    cnt_d   = 5'd0;
                    busy_d  = 1'b1;
                    state_d = DIV;
                end
            end
            DIV: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd0) begin
                    rem_d = lt ? {1'b0, m1, 1'b0} : {2'b00, m1};
                    exp_d = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                            + 10'sd127 - (lt ? 10'sd1 : 10'sd0);
                    quo_d = 26'd0;
                end else if (rem_q >= {2'b00, m2}) begin
                    rem_d = (rem_q - {2'b00, m2}) << 1;
                    quo_d = {quo_q[24:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    quo_d = {quo_q[24:0], 1'b0};
                end
                if (cnt_q == 5'd26) state_d = RND;
            end
            RND: begin
                done_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = IDLE;
                ovf_d   = 1'b0;
                if (exp_r >= 10'sd255) begin
                    y_d   = {sgn, 8'hFF, 23'd0};
                    ovf_d = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    y_d = {sgn, 31'd0};
                end else begin
                    y_d = {sgn, exp_r[7:0], frac_r};
                end
`ifdef FDIV_SPECIAL_EN
                if (spec_nan) begin
                    y_d   = 32'h7FC00000;
                    ovf_d = 1'b0;
                end else if (a_inf || b_zero) begin
                    y_d   = {sgn, 8'hFF, 23'd0};
                    ovf_d = 1'b0;
                end else if (a_zero || b_inf) begin
                    y_d   = {sgn, 31'd0};
                    ovf_d = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            rem_q   <= 26'd0;
            quo_q   <= 26'd0;
            exp_q   <= 10'sd0;
            y_q     <= 32'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_fdiv_unit.sv
// Scoreboard bench for fdiv_unit: directed vectors plus an exponent/fraction sweep checked against a real-valued reference.
module tb_fdiv_unit;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] x1, x2, y;
    logic        ovf, busy, done;

    fdiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2),
        .y(y), .ovf(ovf), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bnd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ey;
        logic        eo;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic real f2r(input logic [31:0] v);
        real m;
        if (v[30:23] == 8'h00) return 0.0;
        m = (1.0 + real'(int'(v[22:0])) / 8388608.0) * (2.0 ** (real'(int'(v[30:23])) - 127.0));
        return v[31] ? -m : m;
    endfunction

    task automatic check_one(input exp_t e);
        real ex, ax, err;
        logic s;
        if (!e.bnd) begin
            chk("directed", (y == e.ey) && (ovf == e.eo), {31'd0, ovf, y}, {31'd0, e.eo, e.ey});
        end else begin
            ex = f2r(e.a) / f2r(e.b);
            ax = (ex < 0.0) ? -ex : ex;
            s  = e.a[31] ^ e.b[31];
            if (ax >= (2.0 ** 128) - (2.0 ** 103)) begin
                chk("sweep_ovf", (y == {s, 8'hFF, 23'd0}) && ovf, {31'd0, ovf, y}, {31'd1, s, 8'hFF, 23'd0});
            end else begin
                err = f2r(y) - ex;
                if (err < 0.0) err = -err;
                chk("sweep_val", !ovf && (y[30:23] != 8'hFF) &&
                    ((err < ax * (2.0 ** -22)) || (err < (2.0 ** -126))),
                    {31'd0, ovf, y}, $realtobits(ex));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) chk("unexpected_done", 1'b0, {31'd0, ovf, y}, 64'd0);
            else check_one(sb.pop_front());
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) chk("idle_timeout", 1'b0, 64'd1, 64'd0);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 1'b0, 64'd0, 64'd1);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic bnd,
                         input logic [31:0] ey, input logic eo, input logic psh);
        exp_t e;
        wait_idle();
        e = {bnd, a, b, ey, eo};
        if (psh) sb.push_back(e);
        x1 = a;
        x2 = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x1 = $urandom;
        x2 = $urandom;
    endtask

    function automatic logic [22:0] frac_pick(input int k);
        case (k)
            0: return 23'd0;
            1: return 23'd1;
            2: return 23'd2;
            3: return 23'(7 << 19);
            4: return 23'(1 << 22);
            5: return 23'h7FFFFF;
            default: return 23'($urandom);
        endcase
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, d0;
        logic busy_ok;
        logic [7:0] es [9];
        logic [31:0] a, b;
        es = '{8'd1, 8'd2, 8'd63, 8'd126, 8'd127, 8'd128, 8'd200, 8'd253, 8'd254};
        rst = 1'b1;
        start = 1'b0;
        x1 = 32'd0;
        x2 = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_y", y == 32'd0, {32'd0, y}, 64'd0);
        chk("reset_ovf", ovf == 1'b0, {63'd0, ovf}, 64'd0);
        chk("reset_busy", busy == 1'b0, {63'd0, busy}, 64'd0);
        chk("reset_done", done == 1'b0, {63'd0, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // latency and busy profile of a single divide
        sb.push_back({1'b0, 32'h3F800000, 32'h40000000, 32'h3F000000, 1'b0});
        x1 = 32'h3F800000;
        x2 = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        x1 = 32'hDEADBEEF;
        x2 = 32'h00000000;
        chk("busy_rise", busy == 1'b1, {63'd0, busy}, 64'd1);
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat == 28, 64'(lat), 64'd28);
        chk("busy_held", busy_ok, {63'd0, busy_ok}, 64'd1);
        @(posedge clk);
        #1;
        chk("busy_release", (busy == 1'b0) && (done == 1'b0), {62'd0, busy, done}, 64'd0);

        issue(32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAB, 1'b0, 1'b1);
        issue(32'hC0C00000, 32'h40000000, 1'b0, 32'hC0400000, 1'b0, 1'b1);
        issue(32'h7F000000, 32'h00800000, 1'b0, 32'h7F800000, 1'b1, 1'b1);
        issue(32'h00800000, 32'h7F000000, 1'b0, 32'h00000000, 1'b0, 1'b1);
        issue(32'hBF800000, 32'h3F800000, 1'b0, 32'hBF800000, 1'b0, 1'b1);

        // starts while busy and during the done cycle must be dropped
        wait_idle();
        d0 = n_done;
        issue(32'h40000000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        x1 = 32'h40400000;
        x2 = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        x1 = 32'h3F800000;
        x2 = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignored_starts", n_done == d0 + 1, 64'(n_done - d0), 64'd1);
        chk("idle_after_ignore", busy == 1'b0, {63'd0, busy}, 64'd0);

        // reset at cycle 10 aborts without a done
        d0 = n_done;
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy == 1'b0, {63'd0, busy}, 64'd0);
        chk("abort_done", done == 1'b0, {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done == d0, 64'(n_done - d0), 64'd0);

        // exponent / edge-fraction sweep
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 9; j++) begin
                a = {1'($urandom), es[i], frac_pick((i + j) % 7)};
                b = {1'($urandom), es[j], frac_pick((i * 3 + j + 1) % 7)};
                issue(a, b, 1'b1, 32'd0, 1'b0, 1'b1);
            end
        end
        for (int k = 0; k < 20; k++) begin
            a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            b = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            issue(a, b, 1'b1, 32'd0, 1'b0, 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size() == 0, 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
